funct_generator_xfade_sel: RTL and testbench
============================================

// Module: funct_generator_xfade_sel
// PURPOSE
//  N_CH-channel registered waveform selector for the function generator. It sits between the waveform cores and the sample FIFO.
//  Samples on sample_stb_i and drives a valid/ready stream into the FIFO.
//  When sel_i changes, it switches with a linear crossfade over 2**RAMP_LOG2 samples, so the output has no step discontinuity.
//  en_i low forces a zero-valued stream. The stream keeps running, so FIFO timing is preserved.
// PARAMETERS
//  DATA_WIDTH  32  sample width; signed fixed point [3:4-DATA_WIDTH] (4 integer bits, DATA_WIDTH-4 fraction bits)
//  N_CH        4   number of input channels; >=2
//  RAMP_LOG2   4   crossfade length = 2**RAMP_LOG2 accepted samples; 1..8
//  SEL_W       $clog2(N_CH)  localparam; selector width
// PORTS
//  clk_i        in   1                   clock
//  rst_ni       in   1                   asynchronous reset, active low
//  en_i         in   1                   output enable (level)
//  sel_i        in   SEL_W               requested channel (level)
//  sample_stb_i in   1                   one-cycle pulse: data_i holds a new sample set
//  data_i       in   [N_CH][DATA_WIDTH]  signed channel samples
//  data_o       out  DATA_WIDTH          signed output sample, registered
//  valid_o      out  1                   data_o holds an unconsumed sample
//  ready_i      in   1                   FIFO accepts data_o when valid_o && ready_i
//  cur_sel_o    out  SEL_W               channel currently being faded to / output
//  busy_o       out  1                   crossfade in progress (state XFADE)
//  overrun_o    out  1                   one-cycle pulse: strobe dropped because output was stalled
// BEHAVIOUR
//  Reset (async, rst_ni=0): state=OFF, data_o=0, valid_o=0, cur_sel_o=0, old_sel=0, k=0, busy_o=0, overrun_o=0.
//  Accept: a strobe is accepted iff (!valid_o || ready_i) in that cycle.
//    If accepted, data_o loads and valid_o=1 on the next edge; latency is 1 clk.
//    If not accepted, the sample is dropped, overrun_o=1 for 1 clk, and state and k do not change.
//  Drain: valid_o clears on (valid_o && ready_i && !accepted strobe). data_o is held stable while valid_o && !ready_i.
//  States: OFF, RUN, XFADE. Transitions are evaluated only on accepted strobes, except en_i=0 (below).
//    OFF:   emitted sample = 0. On an accepted strobe with en_i=1: cur_sel=sel_i (if valid), ->RUN, and this sample = data_i[cur_sel].
//    RUN:   emitted sample = data_i[cur_sel].
//           On an accepted strobe where sel_i != cur_sel and sel_i < N_CH: old_sel=cur_sel, cur_sel=sel_i, k=1, ->XFADE.
//           That same sample is already the k=1 blend.
//    XFADE: emitted sample = old + (((new-old)*k) >>> RAMP_LOG2), where old=data_i[old_sel] and new=data_i[cur_sel].
//           k increments per accepted strobe. The sample with k==2**RAMP_LOG2 equals new exactly; state ->RUN after it.
//           sel_i changes during XFADE are ignored; sel_i is a level and is re-evaluated once in RUN.
//  en_i=0: in any state, next clk state=OFF, k=0, busy_o=0. Accepted strobes emit 0.
//    A sample already in data_o is not altered.
//  sel_i >= N_CH: ignored (cur_sel kept); no crossfade started.
//  Arithmetic: diff is DATA_WIDTH+1 bits signed; the product is DATA_WIDTH+RAMP_LOG2+2 bits signed.
//    >>> is an arithmetic shift (floor). The result lies between old and new, so truncation to DATA_WIDTH never overflows.
//  Simultaneous strobe + ready_i with valid_o=1: the old sample is consumed and the new one loaded in the same edge; valid_o stays 1.
//  Reset mid-crossfade: abandons the ramp; after reset, behaviour is as from power-up.
// STRUCTURE
//  funct_generator_pkg: typedef enum logic [1:0] {OFF, RUN, XFADE} fg_sel_state_e; RAMP_LOG2_MAX=8; sample typedef helper.
//  Sub-module funct_generator_lerp: combinational interpolator (old, new, k) -> blended sample, parameters DATA_WIDTH and RAMP_LOG2.
//  Top: state register, k counter, sel registers, output register + handshake, overrun pulse.
// TESTING (DATA_WIDTH=32, N_CH=4, RAMP_LOG2=2; ch0=0x0000_0000, ch1=0x1000_0000, ready_i=1 unless noted)
//  1. Reset: assert rst_ni=0 mid-stream -> data_o=0, valid_o=0, busy_o=0 immediately; the first strobe after en_i=1, sel_i=1 -> data_o=0x1000_0000 1 clk later.
//  2. Crossfade: RUN on ch0; set sel_i=1 and apply 5 strobes -> outputs 0x0400_0000, 0x0800_0000, 0x0C00_0000, 0x1000_0000, 0x1000_0000.
//     busy_o is high for exactly the first 4 of those samples.
//  3. Negative ramp: ch0=0, ch1=0xF000_0001; sel 0->1 -> every blended sample is floor-correct, and the 4th sample equals 0xF000_0001 exactly.
//  4. Backpressure: ready_i=0 with valid_o=1; strobe -> overrun_o pulse, data_o unchanged, k unchanged.
//     Then ready_i=1 with a strobe in the same cycle -> new sample loaded and valid_o stays 1.
//  5. en_i dropped mid-XFADE (k=2) -> next strobe emits 0 and busy_o=0; re-enable with sel_i=3 -> RUN on ch3 with no crossfade.
//  6. sel_i changed during XFADE and sel_i=N_CH-invalid in RUN -> ramp finishes untouched; the invalid select leaves cur_sel_o unchanged.

Source files
------------

// File: rtl/funct_generator_pkg.sv
// Shared types and helpers for the function-generator waveform selector.
// Holds the selector state encoding and ramp-length helpers.
package funct_generator_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    RUN   = 2'd1,
    XFADE = 2'd2
  } fg_sel_state_e;

  localparam int RAMP_LOG2_MAX    = 8;
  localparam int SAMPLE_W_DEFAULT = 32;

  typedef logic signed [SAMPLE_W_DEFAULT-1:0] fg_sample_t;

  // Crossfade length in accepted samples, clamped to the supported range.
  function automatic int fg_ramp_len(input int ramp_log2);
    int l2;
    l2 = (ramp_log2 > RAMP_LOG2_MAX) ? RAMP_LOG2_MAX : ramp_log2;
    return 1 << l2;
  endfunction

endpackage

// File: rtl/funct_generator_lerp.sv
// Combinational linear interpolator: old + floor((new - old) * k / 2**RAMP_LOG2).
// The result always lies between old and new, so the final truncation is lossless.
module funct_generator_lerp #(
  parameter int DATA_WIDTH = 32,
  parameter int RAMP_LOG2  = 4
) (
  input  logic signed [DATA_WIDTH-1:0] old_smp,
  input  logic signed [DATA_WIDTH-1:0] new_smp,
  input  logic        [RAMP_LOG2:0]    k,
  output logic signed [DATA_WIDTH-1:0] blend
);
  localparam int PW = DATA_WIDTH + RAMP_LOG2 + 2;

  logic signed [DATA_WIDTH:0] diff;
  logic signed [PW-1:0]       prod;

  always_comb begin
    diff  = $signed({new_smp[DATA_WIDTH-1], new_smp}) - $signed({old_smp[DATA_WIDTH-1], old_smp});
    prod  = PW'(diff) * $signed(PW'({1'b0, k}));
    blend = DATA_WIDTH'(PW'(old_smp) + (prod >>> RAMP_LOG2));
  end

endmodule

// File: rtl/funct_generator_xfade_sel.sv
// Registered N-channel waveform selector with linear crossfade on channel change,
// feeding a valid/ready sample stream into the FIFO.
module funct_generator_xfade_sel
  import funct_generator_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  N_CH       = 4,
  parameter int  RAMP_LOG2  = 4,
  localparam int SEL_W      = $clog2(N_CH)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              en_i,
  input  logic [SEL_W-1:0]                  sel_i,
  input  logic                              sample_stb_i,
  input  logic [N_CH-1:0][DATA_WIDTH-1:0]   data_i,
  output logic signed [DATA_WIDTH-1:0]      data_o,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [SEL_W-1:0]                  cur_sel_o,
  output logic                              busy_o,
  output logic                              overrun_o
);
  localparam int            KW     = RAMP_LOG2 + 1;
  localparam logic [KW-1:0] K_FULL = KW'(fg_ramp_len(RAMP_LOG2));

  fg_sel_state_e               state_q, state_d;
  logic [KW-1:0]               k_q, k_d;
  logic [SEL_W-1:0]            cur_q, cur_d, old_q, old_d;
  logic                        accept;
  logic signed [DATA_WIDTH-1:0] old_smp, new_smp, blend, sample;

  function automatic logic sel_ok(input logic [SEL_W-1:0] s);
    return int'(s) < N_CH;
  endfunction

  // k_q is the ramp position of the sample currently held in data_o.
  always_comb begin
    accept  = sample_stb_i && (!valid_o || ready_i);
    state_d = state_q;
    k_d     = k_q;
    cur_d   = cur_q;
    old_d   = old_q;
    if (!en_i) begin
      state_d = OFF;
      k_d     = '0;
    end else if (accept) begin
      unique case (state_q)
        OFF: begin
          if (sel_ok(sel_i)) cur_d = sel_i;
          state_d = RUN;
        end
        RUN: begin
          if (sel_ok(sel_i) && (sel_i != cur_q)) begin
            old_d   = cur_q;
            cur_d   = sel_i;
            k_d     = KW'(1);
            state_d = XFADE;
          end
        end
        XFADE: begin
          if (k_q == K_FULL) begin
            k_d     = '0;
            state_d = RUN;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
        default: state_d = OFF;
      endcase
    end
  end

  // The emitted sample is derived from the post-transition state.
  always_comb begin
    old_smp = $signed(data_i[old_d]);
    new_smp = $signed(data_i[cur_d]);
    unique case (state_d)
      RUN:     sample = new_smp;
      XFADE:   sample = blend;
      default: sample = '0;
    endcase
  end

  funct_generator_lerp #(
    .DATA_WIDTH (DATA_WIDTH),
    .RAMP_LOG2  (RAMP_LOG2)
  ) u_lerp (
    .old_smp (old_smp),
    .new_smp (new_smp),
    .k       (k_d),
    .blend   (blend)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= OFF;
      k_q       <= '0;
      cur_q     <= '0;
      old_q     <= '0;
      data_o    <= '0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      overrun_o <= sample_stb_i && !accept;
      if (accept) begin
        data_o  <= sample;
        valid_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
      if (accept || !en_i) begin
        state_q <= state_d;
        k_q     <= k_d;
        cur_q   <= cur_d;
        old_q   <= old_d;
      end
    end
  end

  assign busy_o    = (state_q == XFADE);
  assign cur_sel_o = cur_q;

endmodule

// File: tb/tb_funct_generator_xfade_sel.sv
// Bench for funct_generator_xfade_sel: directed scenarios then randomized traffic,
// all checked every cycle against an arithmetic reference model.
module tb_funct_generator_xfade_sel;
  localparam int DW = 32;
  localparam int NC = 4;
  localparam int RL = 2;
  localparam int RAMP = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [1:0]        sel;
  logic              stb;
  logic              rdy;
  logic [3:0][31:0]  din;

  logic [31:0] data_o;
  logic        valid_o, busy_o, overrun_o;
  logic [1:0]  cur_sel_o;

  logic [31:0] data_b;
  logic        valid_b, busy_b, over_b;
  logic [1:0]  cur_b;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: mode 0=off 1=run 2=fading
  int          m_mode, m_cur, m_old, m_k;
  logic [31:0] m_data;
  bit          m_valid, m_over;

  always #5 clk = ~clk;

  funct_generator_xfade_sel #(.DATA_WIDTH(DW), .N_CH(NC), .RAMP_LOG2(RL)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .sel_i(sel), .sample_stb_i(stb),
    .data_i(din), .data_o(data_o), .valid_o(valid_o), .ready_i(rdy),
    .cur_sel_o(cur_sel_o), .busy_o(busy_o), .overrun_o(overrun_o)
  );

  funct_generator_xfade_sel #(.DATA_WIDTH(DW), .N_CH(3), .RAMP_LOG2(RL)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .sel_i(sel), .sample_stb_i(stb),
    .data_i(din[2:0]), .data_o(data_b), .valid_o(valid_b), .ready_i(rdy),
    .cur_sel_o(cur_b), .busy_o(busy_b), .overrun_o(over_b)
  );

  function automatic logic [31:0] blend(input logic [31:0] o, input logic [31:0] n, input int k);
    longint lo, ln, num, q, r;
    lo  = longint'($signed(o));
    ln  = longint'($signed(n));
    num = (ln - lo) * k;
    q   = num / RAMP;
    if ((num % RAMP != 0) && (num < 0)) q = q - 1;
    r = lo + q;
    return r[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    m_mode = 0; m_cur = 0; m_old = 0; m_k = 0;
    m_data = '0; m_valid = 0; m_over = 0;
  endtask

  task automatic model_step();
    bit          acc;
    logic [31:0] out;
    acc    = stb && (!m_valid || rdy);
    m_over = stb && !acc;
    out    = '0;
    if (acc) begin
      if (en) begin
        case (m_mode)
          0: begin
            if (int'(sel) < NC) m_cur = int'(sel);
            m_mode = 1;
            out = din[m_cur];
          end
          1: begin
            if (int'(sel) < NC && int'(sel) != m_cur) begin
              m_old = m_cur; m_cur = int'(sel); m_k = 1; m_mode = 2;
              out = blend(din[m_old], din[m_cur], 1);
            end else begin
              out = din[m_cur];
            end
          end
          default: begin
            if (m_k == RAMP) begin
              m_mode = 1; m_k = 0;
              out = din[m_cur];
            end else begin
              m_k++;
              out = blend(din[m_old], din[m_cur], m_k);
            end
          end
        endcase
      end
      m_data = out; m_valid = 1;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    if (!en) begin m_mode = 0; m_k = 0; end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data"},    data_o,           m_data);
    chk({tag, ".valid"},   32'(valid_o),     32'(m_valid));
    chk({tag, ".busy"},    32'(busy_o),      32'(m_mode == 2));
    chk({tag, ".cur_sel"}, 32'(cur_sel_o),   32'(m_cur));
    chk({tag, ".overrun"}, 32'(overrun_o),   32'(m_over));
  endtask

  task automatic tick(input string tag = "cyc");
    if (!rst_n) reset_model(); else model_step();
    @(posedge clk); #1;
    check_all(tag);
  endtask

  task automatic strobe(input string tag = "stb");
    stb = 1'b1; tick(tag); stb = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; #1;
    reset_model();
    chk("rst.data_now",  data_o,        32'h0);
    chk("rst.valid_now", 32'(valid_o),  32'h0);
    chk("rst.busy_now",  32'(busy_o),   32'h0);
    tick("rst");
    rst_n = 1'b1;
  endtask

  logic [31:0] exp2 [5];
  logic        busy2 [5];
  logic [31:0] prev;

  initial begin
    rst_n = 1'b0; en = 1'b0; sel = 2'd0; stb = 1'b0; rdy = 1'b1;
    din[0] = 32'h0000_0000; din[1] = 32'h1000_0000;
    din[2] = 32'h2345_6789; din[3] = 32'hC000_0010;
    exp2  = '{32'h0400_0000, 32'h0800_0000, 32'h0C00_0000, 32'h1000_0000, 32'h1000_0000};
    busy2 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    reset_model();

    // 1: reset, first sample, reset mid-crossfade, first sample again
    tick("por"); tick("por");
    rst_n = 1'b1; en = 1'b1; sel = 2'd1;
    tick();
    strobe("t1");
    chk("t1.first", data_o, 32'h1000_0000);
    sel = 2'd0; strobe(); strobe();
    do_reset();
    tick();
    sel = 2'd1; strobe("t1b");
    chk("t1.after_rst", data_o, 32'h1000_0000);
    chk("t1.after_rst_busy", 32'(busy_o), 32'h0);

    // 2: crossfade ch0 -> ch1
    do_reset();
    sel = 2'd0; strobe();
    sel = 2'd1;
    for (int i = 0; i < 5; i++) begin
      strobe("t2");
      chk($sformatf("t2.ramp%0d", i), data_o, exp2[i]);
      chk($sformatf("t2.busy%0d", i), 32'(busy_o), 32'(busy2[i]));
    end

    // 3: negative ramp ch0 -> ch1 = 0xF000_0001
    din[1] = 32'hF000_0001;
    do_reset();
    sel = 2'd0; strobe();
    sel = 2'd1;
    for (int i = 1; i <= 4; i++) begin
      strobe("t3");
      chk($sformatf("t3.blend%0d", i), data_o, blend(32'h0, 32'hF000_0001, i));
    end
    chk("t3.exact_end", data_o, 32'hF000_0001);

    // 4: backpressure during a ramp ch1 -> ch0
    strobe();
    sel = 2'd0; strobe("t4");
    prev = data_o;
    rdy = 1'b0; strobe("t4s");
    chk("t4.overrun", 32'(overrun_o), 32'h1);
    chk("t4.held", data_o, prev);
    tick("t4w");
    chk("t4.pulse_end", 32'(overrun_o), 32'h0);
    rdy = 1'b1; strobe("t4r");
    chk("t4.k_kept", data_o, blend(32'hF000_0001, 32'h0, 2));
    chk("t4.valid_kept", 32'(valid_o), 32'h1);

    // 5: enable dropped at k=2, re-enable straight onto ch3
    en = 1'b0; strobe("t5");
    chk("t5.zero", data_o, 32'h0);
    chk("t5.busy", 32'(busy_o), 32'h0);
    en = 1'b1; sel = 2'd3; strobe("t5e");
    chk("t5.ch3", data_o, din[3]);
    chk("t5.cur3", 32'(cur_sel_o), 32'd3);
    chk("t5.nofade", 32'(busy_o), 32'h0);

    // 6: select changes during a ramp are ignored until RUN
    sel = 2'd1; strobe("t6");
    sel = 2'd2;
    for (int i = 0; i < 4; i++) strobe("t6");
    chk("t6.cur", 32'(cur_sel_o), 32'd1);
    chk("t6.end", data_o, din[1]);
    strobe("t6r");
    chk("t6.reeval", 32'(cur_sel_o), 32'd2);
    chk("t6.refade", 32'(busy_o), 32'h1);

    // 6b: out-of-range select on the 3-channel instance
    do_reset();
    sel = 2'd1; strobe();
    sel = 2'd3; strobe();
    chk("t6b.cur", 32'(cur_b), 32'd1);
    chk("t6b.busy", 32'(busy_b), 32'h0);
    chk("t6b.data", data_b, din[1]);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      stb = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 3) != 0);
      en  = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 5) == 0) sel = 2'($urandom_range(0, 3));
      for (int c = 0; c < 4; c++) begin
        case ($urandom_range(0, 7))
          0:       din[c] = 32'h7FFF_FFFF;
          1:       din[c] = 32'h8000_0000;
          default: din[c] = $urandom;
        endcase
      end
      if ($urandom_range(0, 249) == 0) begin
        stb = 1'b0;
        do_reset();
      end else begin
        tick("rnd");
      end
    end
    stb = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
